bcd_display_counter: RTL

Parametrised multi-digit BCD up/down counter driving a time-multiplexed common-anode 7-segment display. It generalises the single-digit 0–9 display counter to DIGITS digits, with up/down mode, synchronous load, enable, and a wrap flag. The block sits at the board top level between the system clock and the display pins. All step and scan timing is derived from `clk` by internal prescalers; there is no derived clock domain.

---
 rtl/bcd_display_counter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/bcd_display_counter.sv
// Multi-digit BCD up/down counter with load, enable and wrap pulse, driving a
// time-multiplexed common-anode 7-segment display (active-low seg and an).
module bcd_display_counter #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 25_000_000,
    parameter int SCAN_DIV = 50_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  wrap,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(DIGITS - 1);

    logic [PW-1:0]         pre;
    logic [SW-1:0]         scan_cnt;
    logic [IW-1:0]         idx;
    logic                  step;
    logic [4*DIGITS-1:0]   inc_val;
    logic [4*DIGITS-1:0]   dec_val;
    logic [4*DIGITS-1:0]   load_clean;
    logic                  carry;
    logic                  borrow;
    logic [3:0]            sel_nib;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b0111111;
            4'd1:    decode = 7'b0000110;
            4'd2:    decode = 7'b1011011;
            4'd3:    decode = 7'b1001111;
            4'd4:    decode = 7'b1100110;
            4'd5:    decode = 7'b1101101;
            4'd6:    decode = 7'b1111101;
            4'd7:    decode = 7'b0000111;
            4'd8:    decode = 7'b1111111;
            4'd9:    decode = 7'b1101111;
            default: decode = 7'b0111111;
        endcase
    endfunction

    assign step = en && (pre == PRE_MAX);

    // Ripple carry/borrow; a carry or borrow out of the top digit is the wrap.
    always_comb begin
        inc_val    = count;
        dec_val    = count;
        load_clean = load_val;
        carry      = 1'b1;
        borrow     = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (count[4*i +: 4] == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = count[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (count[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = count[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
            if (load_val[4*i +: 4] > 4'd9) begin
                load_clean[4*i +: 4] = 4'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            pre   <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (load) begin
                count <= load_clean;
                pre   <= '0;
            end else if (step) begin
                count <= up ? inc_val : dec_val;
                wrap  <= up ? carry : borrow;
                pre   <= '0;
            end else if (en) begin
                pre <= pre + PW'(1);
            end
        end
    end

    always_comb begin
        sel_nib = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (IW'(i) == idx) begin
                sel_nib = count[4*i +: 4];
            end
        end
    end

    // an/seg are registered from idx so both switch together, one edge after idx.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            idx      <= '0;
            an       <= ~(DIGITS'(1));
            seg      <= 7'b1000000;
        end else begin
            if (scan_cnt == SCAN_MAX) begin
                scan_cnt <= '0;
                idx      <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
            end else begin
                scan_cnt <= scan_cnt + SW'(1);
            end
            an  <= ~(DIGITS'(1) << idx);
            seg <= ~decode(sel_nib);
        end
    end

endmodule
